// File: rtl/aes_pkg.sv
// Shared AES types and helpers.
//   byte_t      : one state byte
//   state_t     : full 128-bit AES state
//   fsm_t       : SubBytes sequencer FSM encoding (IDLE/RUN/DONE)
//   state_byte  : byte i of a state, byte 0 being the most significant byte
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam int STATE_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    function automatic byte_t state_byte(state_t s, int i);
        return s[8*(STATE_BYTES-1-i) +: 8];
    endfunction

endpackage

// File: rtl/aes_subbytes_seq_if.sv
// Bus bundle of the SubBytes sequencer.
//   in_valid/in_ready/in_state    : state input from the round controller
//   out_valid/out_ready/out_state : substituted state back to the controller
//   sb_addr1/2, sb_data1/2        : the two lanes of the shared S-box ROM
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid and ready are both high; the producer keeps valid and its data
// steady until that edge, and ready may depend combinationally on state only.
// Modports: slave = sequencer side, master = controller/ROM side.
interface aes_subbytes_seq_if #(
    parameter int N_BYTES = 16
);
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [8*N_BYTES-1:0]   in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [8*N_BYTES-1:0]   out_state;
    byte_t                  sb_addr1;
    byte_t                  sb_addr2;
    byte_t                  sb_data1;
    byte_t                  sb_data2;

    modport slave (
        input  in_valid, in_state, out_ready, sb_data1, sb_data2,
        output in_ready, out_valid, out_state, sb_addr1, sb_addr2
    );

    modport master (
        output in_valid, in_state, out_ready, sb_data1, sb_data2,
        input  in_ready, out_valid, out_state, sb_addr1, sb_addr2
    );

endinterface

// File: rtl/aes_subbytes_seq.sv
// AES SubBytes sequencer: streams a latched state through an external
// dual-port S-box ROM, two bytes per cycle, and presents the substituted
// state on a valid/ready output.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   bus       : aes_subbytes_seq_if.slave (input/output handshakes, S-box lanes)
//   busy      : high while in RUN or DONE
//   dbg_state : current FSM state
// Parameters:
//   N_BYTES   : bytes per state (even)
//   SBOX_LAT  : S-box read latency, 0 = combinational, 1 = registered outputs
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int N_BYTES  = 16,
    parameter int SBOX_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_subbytes_seq_if.slave    bus,
    output logic                 busy,
    output fsm_t                 dbg_state
);

    localparam int              N_PAIRS = N_BYTES / 2;
    localparam int              CW      = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(N_PAIRS - 1);
    localparam int              SW      = 8 * N_BYTES;

    fsm_t            state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   idx_q;      // pair index delayed one cycle for a registered ROM
    logic            pend_q;     // a registered-ROM read is due this cycle
    logic            drain_q;    // all addresses issued, waiting for the last data
    logic [SW-1:0]   in_q;
    logic [SW-1:0]   work_q, work_d;
    logic [SW-1:0]   out_q;

    logic            addr_phase;
    logic            wr_en;
    logic            wr_last;
    logic [CW-1:0]   wr_idx;
    int              ra, wa;

    // Capture timing follows the ROM latency: with a combinational ROM the
    // data belongs to the current address pair, otherwise to last cycle's.
    always_comb begin
        addr_phase = (state_q == ST_RUN) && !drain_q;
        wr_en      = (SBOX_LAT == 0) ? addr_phase : pend_q;
        wr_idx     = (SBOX_LAT == 0) ? cnt_q : idx_q;
        wr_last    = wr_en && (wr_idx == LAST);
    end

    // Address lanes: even byte on port 1, odd byte on port 2, zero otherwise.
    always_comb begin
        bus.sb_addr1 = '0;
        bus.sb_addr2 = '0;
        ra           = (N_BYTES - 1 - 2 * int'(cnt_q)) * 8;
        if (addr_phase) begin
            bus.sb_addr1 = in_q[ra +: 8];
            bus.sb_addr2 = in_q[ra - 8 +: 8];
        end
    end

    always_comb begin
        work_d = work_q;
        wa     = (N_BYTES - 1 - 2 * int'(wr_idx)) * 8;
        if (wr_en) begin
            work_d[wa +: 8]     = bus.sb_data1;
            work_d[wa - 8 +: 8] = bus.sb_data2;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
            ST_RUN:  if (wr_last)       state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            drain_q <= 1'b0;
            in_q    <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= addr_phase;
            idx_q   <= cnt_q;
            if (state_q == ST_IDLE && bus.in_valid) begin
                in_q    <= bus.in_state;
                cnt_q   <= '0;
                drain_q <= 1'b0;
                work_q  <= '0;
            end else if (addr_phase) begin
                // The counter parks at the terminal value instead of wrapping.
                if (cnt_q == LAST) drain_q <= (SBOX_LAT != 0);
                else               cnt_q   <= cnt_q + 1'b1;
            end
            if (wr_en)   work_q <= work_d;
            // The visible result only changes when a whole state completes.
            if (wr_last) out_q  <= work_d;
        end
    end

    // in_ready is held low while rst is asserted so nothing looks accepted.
    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_state = out_q;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Bench for aes_subbytes_seq: one instance with a combinational S-box and
// one with a registered S-box, each fed by a ROM model built from GF(2^8)
// arithmetic, plus a scoreboard of expected results per instance.
module tb_aes_subbytes_seq;
    import aes_pkg::*;

    typedef struct {
        int           sel;
        logic [127:0] stim;
        logic [127:0] expv;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(negedge clk) cyc <= cyc + 1;

    // ---------------- DUTs and ROM models ----------------
    aes_subbytes_seq_if #(.N_BYTES(16)) if0();
    aes_subbytes_seq_if #(.N_BYTES(16)) if1();
    logic busy0, busy1;
    fsm_t dbg0, dbg1;

    aes_subbytes_seq #(.N_BYTES(16), .SBOX_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .busy(busy0), .dbg_state(dbg0));
    aes_subbytes_seq #(.N_BYTES(16), .SBOX_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .busy(busy1), .dbg_state(dbg1));

    byte_t sbox_tab [256];

    assign if0.sb_data1 = sbox_tab[if0.sb_addr1];
    assign if0.sb_data2 = sbox_tab[if0.sb_addr2];
    always @(posedge clk) begin
        if1.sb_data1 <= sbox_tab[if1.sb_addr1];
        if1.sb_data2 <= sbox_tab[if1.sb_addr2];
    end

    // ---------------- reference model ----------------
    function automatic byte_t gmul(input byte_t a_in, input byte_t b_in);
        byte_t a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic byte_t rotl8(input byte_t x, input int n);
        return byte_t'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        byte_t inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(byte_t'(x), byte_t'(y)) == 8'h01) inv = byte_t'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] subbytes_ref(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[119:0], sbox_tab[state_byte(s, i)]};
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q0[$];
    logic [127:0] exp_q1[$];
    int in_hs0[$];
    int out_hs0[$];
    logic [127:0] last_out;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (if0.in_valid && if0.in_ready) begin
                exp_q0.push_back(subbytes_ref(if0.in_state));
                in_hs0.push_back(cyc);
            end
            if (if0.out_valid && if0.out_ready) begin
                if (exp_q0.size() == 0) check("sb0_unexpected", if0.out_state, 'x);
                else                    check("sb0_out", if0.out_state, exp_q0.pop_front());
                out_hs0.push_back(cyc);
            end
            if (if1.in_valid && if1.in_ready) exp_q1.push_back(subbytes_ref(if1.in_state));
            if (if1.out_valid && if1.out_ready) begin
                if (exp_q1.size() == 0) check("sb1_unexpected", if1.out_state, 'x);
                else                    check("sb1_out", if1.out_state, exp_q1.pop_front());
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive_in(input int sel, input logic v, input logic [127:0] s);
        if (sel == 0) begin if0.in_valid = v; if0.in_state = s; end
        else          begin if1.in_valid = v; if1.in_state = s; end
    endtask

    task automatic drive_ordy(input int sel, input logic r);
        if (sel == 0) if0.out_ready = r;
        else          if1.out_ready = r;
    endtask

    function automatic logic rd_ir(input int sel);
        return (sel == 0) ? if0.in_ready : if1.in_ready;
    endfunction
    function automatic logic rd_ov(input int sel);
        return (sel == 0) ? if0.out_valid : if1.out_valid;
    endfunction
    function automatic logic rd_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction
    function automatic logic [127:0] rd_os(input int sel);
        return (sel == 0) ? if0.out_state : if1.out_state;
    endfunction
    function automatic logic [15:0] rd_addr(input int sel);
        return (sel == 0) ? {if0.sb_addr1, if0.sb_addr2} : {if1.sb_addr1, if1.sb_addr2};
    endfunction

    // One full transaction; hold = cycles out_ready stays low after out_valid.
    task automatic xact(input int sel, input logic [127:0] st, input int hold);
        int n, lat, exp_lat;
        bit addr_ok, stable_ok;
        logic [15:0] ea;
        logic [127:0] seen;
        exp_lat = (sel == 0) ? 8 : 9;
        drive_ordy(sel, hold == 0);
        drive_in(sel, 1'b1, st);
        n = 0;
        while (!rd_ir(sel) && n < 100) begin @(negedge clk); n++; end
        check("in_accept", 128'(rd_ir(sel)), 128'd1);
        @(negedge clk);
        drive_in(sel, 1'b0, rand128());
        lat = 0;
        addr_ok = 1'b1;
        while (1) begin
            ea = 16'h0000;
            if (!rd_ov(sel) && lat < 8) ea = {state_byte(st, 2*lat), state_byte(st, 2*lat+1)};
            if (rd_addr(sel) !== ea) addr_ok = 1'b0;
            if (rd_ov(sel) || lat >= 100) break;
            @(negedge clk);
            lat++;
        end
        check("latency", 128'(lat), 128'(exp_lat));
        check("addr_trace", 128'(addr_ok), 128'd1);
        seen = rd_os(sel);
        last_out = seen;
        stable_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            drive_in(sel, h == 1, rand128());
            @(negedge clk);
            if (!rd_ov(sel) || rd_ir(sel) || rd_os(sel) !== seen) stable_ok = 1'b0;
        end
        drive_in(sel, 1'b0, rand128());
        if (hold > 0) check("hold_stable", 128'(stable_ok), 128'd1);
        drive_ordy(sel, 1'b1);
        @(negedge clk);
        check("post_idle", 128'({rd_ir(sel), rd_ov(sel), rd_busy(sel)}), 128'(3'b100));
    endtask

    // ---------------- test sequence ----------------
    vec_t tab[6];
    logic [127:0] a_st, b_st;
    int base_in, base_out, n;

    initial begin
        if0.in_valid = 1'b0; if0.in_state = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_state = '0; if1.out_ready = 1'b0;
        build_sbox();

        tab[0] = '{0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
        tab[1] = '{0, 128'h0, {16{8'h63}}};
        tab[2] = '{0, {16{8'hff}}, {16{8'h16}}};
        tab[3] = '{0, {16{8'h53}}, {16{8'hed}}};
        tab[4] = '{1, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
        tab[5] = '{1, {16{8'h01}}, {16{8'h7c}}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(if0.out_valid), 128'd0);
        check("rst_out_state", if0.out_state, 128'd0);
        check("rst_addr", 128'(rd_addr(0)), 128'd0);
        check("rst_busy", 128'({busy0, busy1}), 128'd0);
        check("rst_in_ready", 128'({if0.in_ready, if1.in_ready}), 128'(2'b11));
        check("rst_dbg", 128'(dbg0), 128'(ST_IDLE));

        for (int i = 0; i < 6; i++) begin
            xact(tab[i].sel, tab[i].stim, 0);
            check($sformatf("table_%0d", i), last_out, tab[i].expv);
        end

        // backpressure with an ignored in_valid pulse
        xact(0, rand128(), 5);

        // reset in the middle of RUN, at address cycle 3
        a_st = rand128();
        drive_ordy(0, 1'b1);
        drive_in(0, 1'b1, a_st);
        n = 0;
        while (!if0.in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        drive_in(0, 1'b0, rand128());
        repeat (3) @(negedge clk);
        check("mid_run_addr", 128'(rd_addr(0)), 128'({state_byte(a_st, 6), state_byte(a_st, 7)}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_state", 128'({if0.out_valid, if0.in_ready, busy0}), 128'(3'b010));
        check("abort_out_state", if0.out_state, 128'd0);
        exp_q0.delete();
        xact(0, tab[0].stim, 0);
        check("after_abort", last_out, tab[0].expv);

        // back-to-back with in_valid held high
        a_st = rand128();
        b_st = rand128();
        base_in = in_hs0.size();
        base_out = out_hs0.size();
        drive_ordy(0, 1'b1);
        drive_in(0, 1'b1, a_st);
        n = 0;
        while (in_hs0.size() < base_in + 1 && n < 100) begin @(negedge clk); n++; end
        drive_in(0, 1'b1, b_st);
        while (in_hs0.size() < base_in + 2 && n < 200) begin @(negedge clk); n++; end
        drive_in(0, 1'b0, rand128());
        while (out_hs0.size() < base_out + 2 && n < 300) begin @(negedge clk); n++; end
        check("b2b_outputs", 128'(out_hs0.size() - base_out), 128'd2);
        if (in_hs0.size() >= base_in + 2 && out_hs0.size() >= base_out + 1)
            check("b2b_gap", 128'(in_hs0[base_in + 1]), 128'(out_hs0[base_out] + 1));
        else
            check("b2b_gap", 128'(in_hs0.size() - base_in), 128'd2);

        // randomized traffic with random backpressure
        for (int i = 0; i < 12; i++) xact(0, rand128(), $urandom_range(0, 3));
        for (int i = 0; i < 5; i++)  xact(1, rand128(), $urandom_range(0, 3));

        repeat (3) @(negedge clk);
        check("sb0_drained", 128'(exp_q0.size()), 128'd0);
        check("sb1_drained", 128'(exp_q1.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
